// File: rtl/systolic_skew_feeder.sv
// Splits each accepted 64-bit word into LANES elements and delays lane i by i
// cycles, producing a diagonal wavefront for the systolic array rows.
module systolic_skew_feeder #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   tile_len,
    input  logic [63:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [63:0]        row_data,
    output logic [LANES-1:0]   row_valid,
    output logic               busy,
    output logic               done
);

    localparam int unsigned DW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [DW-1:0]    r_drain;
    logic             w_accept;
    logic             w_last_acc;
    logic             w_drain_end;

    if (LANES * LANE_W != 64) begin : g_bad_cfg
        $error("LANES*LANE_W must equal 64");
    end

    assign w_accept    = in_valid && (r_state == STREAM);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_last_acc  = w_accept && (w_cnt_inc == r_len);
    assign w_drain_end = (r_drain == DW'(LANES - 1));

    assign in_ready = (r_state == STREAM);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (tile_len == '0) ? DONE : STREAM;
            STREAM:  if (w_last_acc) w_next = DRAIN;
            DRAIN:   if (w_drain_end) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_len <= tile_len;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == DRAIN) begin
                r_drain <= r_drain + 1'b1;
            end else begin
                r_drain <= '0;
            end
        end
    end

    // Non-accept cycles inject {0,0}, so bubbles reach the outputs already zeroed.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic              w_ent_v;
        logic [LANE_W-1:0] w_ent_d;
        logic              w_tail_v;
        logic [LANE_W-1:0] w_tail_d;
        logic              r_out_v;
        logic [LANE_W-1:0] r_out_d;

        assign w_ent_v = w_accept;
        assign w_ent_d = w_accept ? in_data[g*LANE_W +: LANE_W] : '0;

        if (g == 0) begin : g_direct
            assign w_tail_v = w_ent_v;
            assign w_tail_d = w_ent_d;
        end else begin : g_delay
            logic              r_dv [g];
            logic [LANE_W-1:0] r_dd [g];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int unsigned j = 0; j < g; j++) begin
                        r_dv[j] <= 1'b0;
                        r_dd[j] <= '0;
                    end
                end else begin
                    r_dv[0] <= w_ent_v;
                    r_dd[0] <= w_ent_d;
                    for (int unsigned j = 1; j < g; j++) begin
                        r_dv[j] <= r_dv[j-1];
                        r_dd[j] <= r_dd[j-1];
                    end
                end
            end

            assign w_tail_v = r_dv[g-1];
            assign w_tail_d = r_dd[g-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_out_v <= 1'b0;
                r_out_d <= '0;
            end else begin
                r_out_v <= w_tail_v;
                r_out_d <= w_tail_v ? w_tail_d : '0;
            end
        end

        assign row_valid[g]                 = r_out_v;
        assign row_data[g*LANE_W +: LANE_W] = r_out_d;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-lane scoreboard queues stamped
// with the cycle each element must appear, checked on every falling edge.
module tb_systolic_skew_feeder;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned LEN_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] tile_len;
    logic [63:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      row_data;
    logic [LANES-1:0] row_valid;
    logic             busy;
    logic             done;

    systolic_skew_feeder #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tile_len  (tile_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_data  (row_data),
        .row_valid (row_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned       due;
        logic [LANE_W-1:0] d;
    } ent_t;

    ent_t        lq [LANES][$];
    int unsigned done_q[$];
    logic [63:0] wq[$];
    int unsigned cyc = 0;
    int unsigned nvec = 0;
    int unsigned nfail = 0;
    int unsigned vcount [LANES];
    int unsigned dcount = 0;
    int unsigned last_acc = 0;
    logic        mon_en = 1'b0;
    logic              mev;
    logic [LANE_W-1:0] med;
    logic              mdone;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < LANES; i++) begin
                mev = 1'b0;
                med = '0;
                if (lq[i].size() > 0 && lq[i][0].due == cyc) begin
                    mev = 1'b1;
                    med = lq[i][0].d;
                    void'(lq[i].pop_front());
                end
                chk($sformatf("lane%0d_valid@%0d", i, cyc), row_valid[i], mev);
                chk($sformatf("lane%0d_data@%0d", i, cyc), row_data[i*LANE_W +: LANE_W], med);
                if (row_valid[i] === 1'b1) vcount[i]++;
            end
            mdone = 1'b0;
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                mdone = 1'b1;
                void'(done_q.pop_front());
            end
            chk($sformatf("done@%0d", cyc), done, mdone);
            if (done === 1'b1) dcount++;
        end
    end

    task automatic drive_word(input logic [63:0] w);
        ent_t e;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < LANES; i++) begin
            e.due = cyc + 1 + i;
            e.d   = w[i*LANE_W +: LANE_W];
            lq[i].push_back(e);
        end
        last_acc = cyc + 1;
        @(negedge clk);
    endtask

    // Called at a falling edge while the DUT is IDLE; returns at the first IDLE cycle after done.
    task automatic run_tile(input int unsigned len, input bit gap, input bit robust);
        int unsigned due;
        start    = 1'b1;
        tile_len = LEN_W'(len);
        due      = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("ready_after_start", in_ready, (len != 0));
        for (int unsigned n = 0; n < len; n++) begin
            if (robust && n == 1) begin
                start    = 1'b1;
                tile_len = 8'd1;
            end
            drive_word(wq[n]);
            start = 1'b0;
            if (gap && n == 0) begin
                in_valid = 1'b0;
                in_data  = {$urandom(), $urandom()};
                @(negedge clk);
            end
        end
        if (len != 0) due = last_acc + LANES;
        done_q.push_back(due);
        in_valid = robust;
        in_data  = 64'hDEAD_BEEF_CAFE_F00D;
        for (int n = 0; n < 64 && cyc < due + 1; n++) @(negedge clk);
        chk("tile_reached_idle", (cyc >= due + 1), 1'b1);
        in_valid = 1'b0;
        chk("busy_idle", busy, 1'b0);
        chk("ready_idle", in_ready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        tile_len = '0;
        in_data  = '0;
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++) vcount[i] = 0;
        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_row_data", row_data, 64'h0);
        chk("rst_row_valid", row_valid, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Basic three-word tile
        wq = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'h000C_000B_000A_0009};
        run_tile(3, 1'b0, 1'b0);

        // One-cycle bubble between two words
        wq = '{{$urandom(), $urandom()}, {$urandom(), $urandom()}};
        run_tile(2, 1'b1, 1'b0);

        // Empty tile
        dcount = 0;
        run_tile(0, 1'b0, 1'b0);
        chk("len0_done_count", dcount, 1);

        // in_valid in IDLE, start and tile_len churn mid-tile, in_valid during DRAIN
        in_valid = 1'b1;
        in_data  = 64'h1111_2222_3333_4444;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wq = '{64'h0A0A_0B0B_0C0C_0D0D, 64'h1234_5678_9ABC_DEF0,
               64'hFFFF_0000_FFFF_0000, 64'h0001_0002_0003_0004};
        run_tile(4, 1'b0, 1'b1);

        // Back-to-back tiles, second one full length
        dcount = 0;
        wq = '{64'h0101_0202_0303_0404, 64'h0505_0606_0707_0808, 64'h0909_0A0A_0B0B_0C0C};
        run_tile(3, 1'b0, 1'b0);
        wq.delete();
        for (int n = 0; n < 255; n++) wq.push_back({$urandom(), $urandom()});
        for (int i = 0; i < LANES; i++) vcount[i] = 0;
        run_tile(255, 1'b0, 1'b0);
        for (int i = 0; i < LANES; i++) chk($sformatf("len255_lane%0d_count", i), vcount[i], 255);
        chk("b2b_done_count", dcount, 2);

        // Asynchronous reset with a tile in flight
        mon_en   = 1'b0;
        start    = 1'b1;
        tile_len = 8'd10;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1;
            in_data  = {$urandom(), $urandom()};
            @(negedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_row_data", row_data, 64'h0);
        chk("midrst_row_valid", row_valid, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        dcount = 0;
        repeat (8) @(negedge clk);
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_no_done", dcount, 0);
        wq = '{64'h7777_6666_5555_4444};
        run_tile(1, 1'b0, 1'b0);

        for (int i = 0; i < LANES; i++) chk($sformatf("lane%0d_queue_empty", i), lq[i].size(), 0);
        chk("done_queue_empty", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Downstream consumer of the operand buffer's 64-bit stream. Accepts a tile of 64-bit words, splits each into LANES elements, and delays lane i by i cycles so operands enter the systolic array rows in diagonal wavefront order. Bubbles are zero-filled and flagged invalid. Signals done once the last element has left the skew network.

## Interface
- LANES, default 4: number of array rows fed, one element per lane.
- LANE_W, default 16: element width in bits; LANES*LANE_W must equal 64.
- LEN_W, default 8: width of the tile length field.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a tile; sampled only in IDLE.
- tile_len  in  LEN_W  number of 64-bit words in the tile; latched on accepted start.
- in_data  in  64  word from buffer; lane i = in_data[i*LANE_W +: LANE_W].
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  feeder accepts in_data this cycle.
- row_data  out  64  skewed output; lane i at row_data[i*LANE_W +: LANE_W].
- row_valid  out  LANES  per-lane valid for row_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at tile completion.

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: in_ready=0.
  - start=1 latches tile_len and clears the word counter.
  - tile_len=0 goes to DONE; otherwise goes to STREAM.
- STREAM: in_ready=1.
  - A word is accepted when in_valid&&in_ready.
  - Counter increments per accept.
  - The accept that makes count equal tile_len moves to DRAIN.
- DRAIN: in_ready=0.
  - Runs a cycle counter for LANES cycles, then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Skew network:
  - Lane i is an i-stage delay line of {valid, element}, followed by a shared output register stage.
  - All stages shift every cycle regardless of state.
  - Entry each cycle:
    - on accept: {1, lane data};
    - otherwise: {0, 0}.
- Invalid lanes present row_data lane = 0. Never stale data.
- start while busy is ignored. in_valid outside STREAM is ignored.
- tile_len is sampled only at start; later changes have no effect.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, all delay stages cleared.
  - Outputs: in_ready=0, row_data=0, row_valid=0, busy=0, done=0.
  - Reset mid-tile discards all in-flight data; no done pulse.
- start accepted at edge k: busy=1 and in_ready=1 from cycle k+1.
- Word accepted at edge t:
  - lane 0 valid at t+1;
  - lane i valid at t+1+i.
- Back-to-back accepts give continuous per-lane valid streams. An in_valid=0 gap in STREAM gives a one-cycle row_valid gap in every lane, skewed identically.
- Last accept at edge t:
  - DRAIN occupies cycles t+1..t+LANES;
  - last row_valid[LANES-1] is high at cycle t+LANES;
  - done=1 at cycle t+LANES+1;
  - busy falls and IDLE is reached at t+LANES+2.
- tile_len=0: start at edge k gives done=1 at k+1, no row_valid activity, IDLE at k+2.
- Earliest next start: the IDLE cycle after done.

## Test plan
- Reset: rst=0 mid-STREAM with data in flight.
  - Required: all outputs 0 immediately (asynchronous), IDLE after release, no done pulse.
- tile_len=3, in_valid held high, words 0x0004_0003_0002_0001, 0x0008_0007_0006_0005, 0x000C_000B_000A_0009.
  - Required: lane0 gives 1,5,9 at t0+1..t0+3.
  - Required: lane3 gives 4,8,C at t0+4..t0+6.
  - Required: done at the cycle after lane3's 0xC.
- Bubble: tile_len=2, in_valid deasserted one cycle between the words.
  - Required: each lane shows valid, invalid (data 0), valid, shifted by lane index.
  - Required: done 5 cycles after the second accept.
- tile_len=0.
  - Required: done one cycle after start, in_ready never high, row_valid stays 0.
- Protocol robustness: start pulsed during STREAM, in_valid high in IDLE/DRAIN, tile_len changed mid-tile.
  - Required: no effect on word count, output data or done timing.
- Back-to-back tiles: second start issued in the first IDLE cycle after done, tile_len=255 with continuous in_valid.
  - Required: 255 valid words per lane, counter ends at 255 with no overflow, done asserted once per tile.
